// File: rtl/mem_stage_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_stage_if
// Brief    : Data-memory req/ack port shared by the MEM stage and its memory.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_stage
// Brief    : RISC-V MEM stage with req/ack word access, timeout abort and MEM/WB register.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        RegWriteM,
  input  wire logic        MemWriteM,
  input  wire logic [1:0]  ResultSrcM,
  input  wire logic [4:0]  rdM,
  input  wire logic [31:0] PCplus4M,
  input  wire logic [31:0] ALUResultM,
  input  wire logic [31:0] WriteDataM,
  mem_stage_if.master      dmem,
  output logic             StallM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [4:0]       rdW,
  output logic [31:0]      PCplus4W,
  output logic [31:0]      ALUResultW,
  output logic [31:0]      ReadDataW,
  output logic             misalign_err,
  output logic             timeout_err
);

  localparam logic [7:0] c_WCNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_wcnt, w_wcnt_nxt;
  logic        w_memop, w_aligned;
  logic        w_req, w_stall, w_capture, w_use_rdata, w_set_mis, w_set_to;

  logic        r_regw;
  logic [1:0]  r_rsrc;
  logic [4:0]  r_rd;
  logic [31:0] r_pc4, r_alu, r_rdata;
  logic        r_mis, r_to;

  assign w_memop   = MemWriteM | (ResultSrcM == 2'b01);
  assign w_aligned = (ALUResultM[1:0] == 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_capture   = 1'b0;
    w_use_rdata = 1'b0;
    w_set_mis   = 1'b0;
    w_set_to    = 1'b0;
    case (r_state)
      S_IDLE, S_BUSY: begin
        if (w_memop && w_aligned) begin
          w_req = 1'b1;
          if (dmem.dmem_ack) begin
            w_capture   = 1'b1;
            w_use_rdata = 1'b1;
            w_state_nxt = S_IDLE;
            w_wcnt_nxt  = '0;
          end else begin
            w_stall    = 1'b1;
            w_wcnt_nxt = r_wcnt + 8'd1;
            // The last unacked request cycle hands over to a single retirement cycle
            if (r_state == S_BUSY && r_wcnt == c_WCNT_LAST) begin
              w_state_nxt = S_ABORT;
            end else begin
              w_state_nxt = S_BUSY;
            end
          end
        end else if (w_memop) begin
          w_set_mis   = (r_state == S_IDLE);
          w_state_nxt = S_IDLE;
          w_wcnt_nxt  = '0;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
          w_wcnt_nxt  = '0;
        end
      end
      S_ABORT: begin
        w_set_to    = 1'b1;
        w_state_nxt = S_IDLE;
        w_wcnt_nxt  = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_regw  <= 1'b0;
      r_rsrc  <= '0;
      r_rd    <= '0;
      r_pc4   <= '0;
      r_alu   <= '0;
      r_rdata <= '0;
      r_mis   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_capture) begin
        r_regw  <= RegWriteM;
        r_rsrc  <= ResultSrcM;
        r_rd    <= rdM;
        r_pc4   <= PCplus4M;
        r_alu   <= ALUResultM;
        r_rdata <= w_use_rdata ? dmem.dmem_rdata : 32'd0;
      end else begin
        r_regw  <= 1'b0;
        r_rsrc  <= '0;
        r_rd    <= '0;
        r_pc4   <= '0;
        r_alu   <= '0;
        r_rdata <= '0;
      end
      r_mis <= r_mis | w_set_mis;
      r_to  <= r_to | w_set_to;
    end
  end

  // Reset gates the combinational handshake outputs so they drop without waiting for an edge
  assign dmem.dmem_req   = w_req & reset;
  assign dmem.dmem_we    = MemWriteM;
  assign dmem.dmem_addr  = ALUResultM;
  assign dmem.dmem_wdata = WriteDataM;
  assign StallM          = w_stall & reset;

  assign RegWriteW    = r_regw;
  assign ResultSrcW   = r_rsrc;
  assign rdW          = r_rd;
  assign PCplus4W     = r_pc4;
  assign ALUResultW   = r_alu;
  assign ReadDataW    = r_rdata;
  assign misalign_err = r_mis;
  assign timeout_err  = r_to;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs (…M signals) and performs word loads and stores through a req/ack data-memory port, stalling the pipeline while an access is outstanding. It contains the MEM/WB pipeline register that feeds write-back (…W signals). It also detects misaligned accesses and memory timeouts, and converts the faulting instruction into a bubble.

## Interface
- TIMEOUT, 16: max request cycles without ack before the access is aborted; legal range 2..255.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. Low clears all state immediately, regardless of clk.
- RegWriteM  in  1  register-write enable from EX/MEM.
- MemWriteM  in  1  store enable from EX/MEM.
- ResultSrcM  in  2  result select from EX/MEM: 00 ALU, 01 load data, 10 PC+4.
- rdM  in  5  destination register.
- PCplus4M  in  32  PC+4 of the instruction.
- ALUResultM  in  32  effective address or ALU result.
- WriteDataM  in  32  store data.
- dmem_req  out  1  memory request. Combinational; forced 0 while reset is low.
- dmem_we  out  1  1 = store, 0 = load. Valid while dmem_req=1.
- dmem_addr  out  32  equals ALUResultM.
- dmem_wdata  out  32  equals WriteDataM.
- dmem_rdata  in  32  load data. Valid in the cycle dmem_ack=1.
- dmem_ack  in  1  access complete. Sampled on the rising edge.
- StallM  out  1  freezes PC, IF/ID, ID/EX and EX/MEM. Combinational; forced 0 while reset is low.
- RegWriteW, ResultSrcW[1:0], rdW[4:0], PCplus4W[31:0], ALUResultW[31:0], ReadDataW[31:0]  out  MEM/WB register outputs.
- misalign_err  out  1  sticky flag: a misaligned access was seen.
- timeout_err  out  1  sticky flag: an access was aborted.

## Operation
- memop = MemWriteM | (ResultSrcM == 01).
- aligned = (ALUResultM[1:0] == 00). Accesses are word-only.
- FSM has three states:
  - IDLE: no access outstanding.
  - BUSY: request outstanding; wait counter wcnt is running.
  - ABORT: one-cycle timeout retirement.
- IDLE or BUSY, memop & aligned:
  - dmem_req=1 and dmem_we=MemWriteM.
  - StallM = ~dmem_ack.
  - If ack=1: MEM/WB captures the instruction with ReadDataW=dmem_rdata, and the state goes to IDLE.
  - If ack=0: MEM/WB captures a bubble, the state goes to BUSY, and wcnt increments (wcnt is 0 in the first request cycle).
- BUSY with wcnt == TIMEOUT-1 and no ack: next state is ABORT.
- ABORT:
  - dmem_req=0 and StallM=0.
  - MEM/WB captures a bubble.
  - timeout_err is set.
  - Next state IDLE; wcnt cleared.
  - Any dmem_ack in this cycle is ignored.
- memop & ~aligned (checked in IDLE):
  - No request, no stall.
  - MEM/WB captures a bubble.
  - misalign_err is set.
- No memop: StallM=0, and MEM/WB captures all …M fields with ReadDataW=0.
- Bubble definition: RegWriteW=0, ResultSrcW=00, rdW=0, PCplus4W=0, ALUResultW=0, ReadDataW=0.
- dmem_ack while dmem_req=0 is ignored.
- Sticky flags clear only on reset.
- Request stability: while stalled, upstream holds EX/MEM, so addr, wdata and we stay constant until ack or abort.

## Timing
- Reset (reset=0): state=IDLE, wcnt=0, every W output =0, both error flags =0, dmem_req=0, StallM=0. The response is immediate and asynchronous.
- Reset deassertion mid-access: the access is abandoned and no write-back occurs. A memop still present on the …M inputs is reissued fresh from IDLE.
- Latency, zero-wait memory (ack in the first request cycle): no stall. MEM/WB is valid 1 cycle after the instruction enters MEM.
- Latency, N wait cycles: StallM is high for N cycles. The W outputs update on the edge where ack=1, which is N+1 edges after entry.
- Timeout: StallM is high for exactly TIMEOUT cycles, then one ABORT cycle with StallM=0. The bubble retires and the next instruction enters on the following edge.
- Back-to-back memops: a new request may be issued in the cycle immediately after an ack, from IDLE. There are no idle cycles between accesses.

## Test plan
- Load, ALUResultM=0x100, ResultSrcM=01, rdM=5, ack in the same cycle with rdata=0xDEADBEEF -> StallM never 1; next edge RegWriteW=1, rdW=5, ReadDataW=0xDEADBEEF.
- Store, ALUResultM=0x200, WriteDataM=0x12345678, ack after 3 wait cycles -> dmem_req=1, dmem_we=1 and StallM=1 for 3 cycles; the retired instruction has RegWriteW=0; addr and wdata are stable throughout.
- Load at ALUResultM=0x102 -> dmem_req never 1; MEM/WB bubble (rdW=0, RegWriteW=0); misalign_err=1 and remains 1 over 10 further cycles.
- With TIMEOUT=4, a load never acked -> StallM=1 for 4 cycles, then 1 ABORT cycle with dmem_req=0; timeout_err=1; an ack asserted in ABORT has no effect on W outputs.
- Reset driven low mid-BUSY, asynchronously between edges -> dmem_req, StallM and all W outputs go to 0 immediately; after release the held load is reissued from IDLE with wcnt=0.
- ALU instruction (ResultSrcM=00, RegWriteM=1, rdM=7, ALUResultM=0x2A) immediately after an acked load -> no stall; W outputs carry rd=7, ALUResultW=0x2A, ReadDataW=0.
